decade_counter_ctrl: RTL and testbench
======================================

# decade_counter_ctrl

Sequencer for a chain of synchronous decade (mod-10) stages forming a DIGITS-wide BCD event counter. Provides run/pause/stop control, parallel BCD load, a programmable terminal value with completion pulse, a tick prescaler, and a valid/ready snapshot port for a downstream reader. It is the control layer that other blocks in the counter family instantiate instead of wiring decade stages and auto-clear logic by hand.

## Interface
- DIGITS, 4: number of BCD digits; legal range 1..8.
- PRESCALE, 1: clocks per count tick; legal range 1..65535.
- clock  in  1  single rising-edge clock.
- clear_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled run request.
- stop  in  1  level-sampled pause/stop request.
- load  in  1  parallel load strobe.
- load_value  in  4*DIGITS  BCD load value; digit 0 = bits [3:0].
- limit  in  4*DIGITS  BCD terminal value.
- snap  in  1  snapshot request.
- rd_ready  in  1  reader accepts snapshot.
- count  out  4*DIGITS  live BCD count.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on RUN→DONE.
- rd_valid  out  1  snapshot available.
- rd_data  out  4*DIGITS  captured count.
- snap_miss  out  1  sticky: snap dropped while rd_valid high.
- dir  in  1  0 = up, 1 = down; present only with BCD_DOWN_EN.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Command priority: stop > start > load.
- IDLE: count held. start→RUN, prescaler cleared. load→count=load_value.
- RUN: each tick increments digit 0; digit 9→0 with carry into the next digit; all-9s→all-0s wrap, no error. If the post-tick count equals limit → DONE and pulse done. stop→PAUSE. load ignored.
- PAUSE: count and prescaler held. start→RUN (prescaler resumes). stop→IDLE with count=0. load→count=load_value.
- DONE: count held at limit. start→RUN with count=0 and prescaler cleared. stop→IDLE with count=0. load→count=load_value, stays DONE.
- load_value digit >9 loads as 0. limit with any digit >9 never matches, so the counter free-runs.
- Tick: prescaler counts 0..PRESCALE-1 only in RUN. Tick is asserted when the prescaler is at PRESCALE-1, then it returns to 0. PRESCALE=1 gives a tick every RUN cycle.
- Snapshot: snap with rd_valid low → rd_data=count (pre-update value of that cycle) and rd_valid=1 at the next edge. rd_valid holds until rd_valid&rd_ready, then clears. snap with rd_valid high sets snap_miss, which stays set until reset. snap in the same cycle as a handshake completion is accepted (captured, rd_valid stays 1).
- Reset (clear_n low, any time including mid-count): state=IDLE, count=0, prescaler=0, busy=0, done=0, rd_valid=0, rd_data=0, snap_miss=0. Takes effect immediately.

## Timing
- All outputs are registered. busy rises on the edge that samples start in IDLE.
- PRESCALE=P: first increment occurs P edges after entering RUN, then every P edges.
- done is high for exactly the one cycle after the edge that wrote limit into count.
- Snapshot latency: 1 clock from snap to rd_valid.
- Load latency: 1 clock.

## Configuration
- BCD_DOWN_EN defined: dir port exists. dir=1 decrements, with digit 0→9 and borrow; all-0s→all-9s wrap. Limit match applies in both directions. dir is sampled per tick.
- BCD_DOWN_EN undefined: no dir port; up-count only.

## Structure
- Package decade_ctrl_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - BCD_MAX=4'd9;
  - digit sanitize function (>9 → 0).
- Sub-module bcd_digit: one 4-bit synchronous mod-10 stage.
  - Inputs: en, load, d, and dir when BCD_DOWN_EN is defined.
  - Outputs: q and carry (high when en and q is at its wrap value).
  - Instantiated DIGITS times in a generate chain.

## Test plan
- Reset then start, DIGITS=4, PRESCALE=1, limit=0012 → count 0001..0012 on consecutive edges; done pulses once; state DONE; count holds 0012.
- load 0099, start, limit=FFFF → count 0100 on first tick; from 9999 the next tick gives 0000 with no done.
- PRESCALE=3: start, stop after 7 clocks, wait 10, start → count advances only in RUN; PAUSE preserves prescaler phase.
- snap while count=0042, rd_ready low 5 cycles, second snap → rd_data=0042 held, snap_miss=1; rd_ready high → rd_valid clears next edge.
- clear_n low mid-RUN at count 0537 → all outputs zero immediately; start afterwards resumes from 0000.
- BCD_DOWN_EN, dir=1, load 0001, start, limit=9998 → 0000, 9999, 9998; done pulses at 9998.

Source files
------------

// File: rtl/decade_ctrl_pkg.sv
// decade_ctrl_pkg: shared types and helpers for the decade counter family.
// Holds the sequencer state enum, the BCD digit limit and digit sanitizing.
package decade_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Non-BCD nibbles are forced to zero so the count stays legal BCD.
    function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
        return (d > BCD_MAX) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one synchronous mod-10 stage. Optional macro: BCD_DOWN_EN.
// Ports: clock, clear_n (async low), en, load, d, [dir], q, carry.
module bcd_digit
    import decade_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       clear_n,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] d,
`ifdef BCD_DOWN_EN
    input  logic       dir,
`endif
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] wrap_val;
    logic [3:0] next_val;

`ifdef BCD_DOWN_EN
    always_comb begin
        wrap_val = dir ? 4'd0 : BCD_MAX;
        if (q == wrap_val) begin
            next_val = dir ? BCD_MAX : 4'd0;
        end else begin
            next_val = dir ? q - 4'd1 : q + 4'd1;
        end
    end
`else
    assign wrap_val = BCD_MAX;
    assign next_val = (q == BCD_MAX) ? 4'd0 : q + 4'd1;
`endif

    assign carry = en & (q == wrap_val);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            q <= 4'd0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= next_val;
        end
    end

endmodule

// File: rtl/decade_counter_ctrl.sv
// decade_counter_ctrl: run/pause/stop sequencer over a DIGITS-wide BCD chain
// with load, terminal-value done pulse, tick prescaler and snapshot port.
// Ports: clock, clear_n, start, stop, load, load_value, limit, snap,
// rd_ready, [dir], count, busy, done, rd_valid, rd_data, snap_miss.
// Optional macro: BCD_DOWN_EN adds dir (1 = count down).
module decade_counter_ctrl
    import decade_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic [4*DIGITS-1:0]   limit,
    input  logic                  snap,
    input  logic                  rd_ready,
`ifdef BCD_DOWN_EN
    input  logic                  dir,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_valid,
    output logic [4*DIGITS-1:0]   rd_data,
    output logic                  snap_miss
);

    localparam int         W     = 4 * DIGITS;
    localparam logic [15:0] PLAST = 16'(PRESCALE - 1);

    state_t        state;
    state_t        state_next;
    logic [15:0]   presc;
    logic [15:0]   presc_next;
    logic          tick;
    logic          hit;
    logic          cnt_load;
    logic          done_next;
    logic          down;
    logic [W-1:0]  load_san;
    logic [W-1:0]  load_data;
    logic [W-1:0]  nxt;
    logic [DIGITS-1:0] en;
    logic [DIGITS-1:0] carry;

`ifdef BCD_DOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    // stop wins over the tick, so a stopping cycle never counts.
    assign tick = (state == RUN) && !stop && (presc == PLAST);

    // Limit is compared against the value the tick is about to write.
    assign hit = (nxt == limit);

    always_comb begin
        load_san = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_san[4*i +: 4] = bcd_sanitize(load_value[4*i +: 4]);
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        // Each stage enables straight from the lower digits' wrap pattern,
        // avoiding a ripple through the carry vector.
        if (i == 0) begin : g_first
            assign en[i] = tick;
        end else begin : g_next
            logic [4*i-1:0] low;
            assign low   = count[4*i-1:0];
            assign en[i] = tick & (down ? (low == '0)
                                        : (low == {i{BCD_MAX}}));
        end

        bcd_digit u_digit (
            .clock   (clock),
            .clear_n (clear_n),
            .en      (en[i]),
            .load    (cnt_load),
            .d       (load_data[4*i +: 4]),
`ifdef BCD_DOWN_EN
            .dir     (dir),
`endif
            .q       (count[4*i +: 4]),
            .carry   (carry[i])
        );

        assign nxt[4*i +: 4] =
            !en[i]   ? count[4*i +: 4] :
            carry[i] ? (down ? BCD_MAX : 4'd0) :
            down     ? count[4*i +: 4] - 4'd1 :
                       count[4*i +: 4] + 4'd1;
    end

    always_comb begin
        state_next = state;
        presc_next = presc;
        cnt_load   = 1'b0;
        load_data  = load_san;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!stop && start) begin
                    state_next = RUN;
                    presc_next = '0;
                end else if (!stop && load) begin
                    cnt_load = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = PAUSE;
                end else if (tick) begin
                    presc_next = '0;
                    if (hit) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end else begin
                    presc_next = presc + 16'd1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_next = IDLE;
                    cnt_load   = 1'b1;
                    load_data  = '0;
                    presc_next = '0;
                end else if (start) begin
                    state_next = RUN;
                end else if (load) begin
                    cnt_load = 1'b1;
                end
            end
            DONE: begin
                if (stop) begin
                    state_next = IDLE;
                    cnt_load   = 1'b1;
                    load_data  = '0;
                    presc_next = '0;
                end else if (start) begin
                    state_next = RUN;
                    cnt_load   = 1'b1;
                    load_data  = '0;
                    presc_next = '0;
                end else if (load) begin
                    cnt_load = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            presc <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            presc <= presc_next;
            busy  <= (state_next == RUN);
            done  <= done_next;
        end
    end

    // A snap landing on the handshake cycle refills the slot.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            snap_miss <= 1'b0;
        end else if (snap && (!rd_valid || rd_ready)) begin
            rd_valid <= 1'b1;
            rd_data  <= count;
        end else if (snap) begin
            snap_miss <= 1'b1;
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decade_counter_ctrl.sv
// tb_decade_counter_ctrl: bench for decade_counter_ctrl, PRESCALE 1 and 3.
// Drives both instances with shared stimulus against an integer model.
module tb_decade_counter_ctrl;

    localparam int MOD = 10000;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clock = 1'b0;
    logic        clear_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        load = 1'b0;
    logic        snap = 1'b0;
    logic        rd_ready = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] load_value = 16'h0;
    logic [15:0] limit = 16'hFFFF;

    logic [15:0] count1, rd_data1, count3, rd_data3;
    logic        busy1, done1, rv1, miss1;
    logic        busy3, done3, rv3, miss3;

    int tests = 0;
    int failed = 0;
    int ndone;

    int P [2] = '{1, 3};
    int m_mode [2];
    int m_cnt [2];
    int m_ph [2];
    int m_rd [2];
    bit m_busy [2];
    bit m_done [2];
    bit m_rv [2];
    bit m_miss [2];

    always #5 clock = ~clock;

    decade_counter_ctrl #(.DIGITS(4), .PRESCALE(1)) dut1 (
        .clock(clock), .clear_n(clear_n), .start(start), .stop(stop),
        .load(load), .load_value(load_value), .limit(limit),
        .snap(snap), .rd_ready(rd_ready),
`ifdef BCD_DOWN_EN
        .dir(dir),
`endif
        .count(count1), .busy(busy1), .done(done1), .rd_valid(rv1),
        .rd_data(rd_data1), .snap_miss(miss1)
    );

    decade_counter_ctrl #(.DIGITS(4), .PRESCALE(3)) dut3 (
        .clock(clock), .clear_n(clear_n), .start(start), .stop(stop),
        .load(load), .load_value(load_value), .limit(limit),
        .snap(snap), .rd_ready(rd_ready),
`ifdef BCD_DOWN_EN
        .dir(dir),
`endif
        .count(count3), .busy(busy3), .done(done3), .rd_valid(rv3),
        .rd_data(rd_data3), .snap_miss(miss3)
    );

    // strict: any non-decimal digit makes the value unmatchable (-1).
    function automatic int bcd2int(input logic [15:0] v, input bit strict);
        int r = 0;
        int d;
        for (int i = 3; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) begin
                if (strict) return -1;
                d = 0;
            end
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE;
            m_cnt[k]  = 0;
            m_ph[k]   = 0;
            m_rd[k]   = 0;
            m_busy[k] = 0;
            m_done[k] = 0;
            m_rv[k]   = 0;
            m_miss[k] = 0;
        end
    endtask

    task automatic model_step();
        int lv  = bcd2int(load_value, 0);
        int lim = bcd2int(limit, 1);
        for (int k = 0; k < 2; k++) begin
            if (snap && (!m_rv[k] || rd_ready)) begin
                m_rd[k] = m_cnt[k];
                m_rv[k] = 1;
            end else if (snap) begin
                m_miss[k] = 1;
            end else if (m_rv[k] && rd_ready) begin
                m_rv[k] = 0;
            end
            m_done[k] = 0;
            case (m_mode[k])
                M_IDLE: begin
                    if (stop) begin
                    end else if (start) begin
                        m_mode[k] = M_RUN;
                        m_ph[k] = 0;
                    end else if (load) begin
                        m_cnt[k] = lv;
                    end
                end
                M_RUN: begin
                    if (stop) begin
                        m_mode[k] = M_PAUSE;
                    end else if (m_ph[k] == P[k] - 1) begin
                        m_ph[k] = 0;
                        m_cnt[k] = dir ? (m_cnt[k] + MOD - 1) % MOD
                                       : (m_cnt[k] + 1) % MOD;
                        if (m_cnt[k] == lim) begin
                            m_mode[k] = M_DONE;
                            m_done[k] = 1;
                        end
                    end else begin
                        m_ph[k]++;
                    end
                end
                M_PAUSE: begin
                    if (stop) begin
                        m_mode[k] = M_IDLE;
                        m_cnt[k] = 0;
                        m_ph[k] = 0;
                    end else if (start) begin
                        m_mode[k] = M_RUN;
                    end else if (load) begin
                        m_cnt[k] = lv;
                    end
                end
                default: begin
                    if (stop) begin
                        m_mode[k] = M_IDLE;
                        m_cnt[k] = 0;
                        m_ph[k] = 0;
                    end else if (start) begin
                        m_mode[k] = M_RUN;
                        m_cnt[k] = 0;
                        m_ph[k] = 0;
                    end else if (load) begin
                        m_cnt[k] = lv;
                    end
                end
            endcase
            m_busy[k] = (m_mode[k] == M_RUN);
        end
    endtask

    task automatic check_all();
        chk("count_p1", count1, int2bcd(m_cnt[0]));
        chk("busy_p1", {15'd0, busy1}, {15'd0, m_busy[0]});
        chk("done_p1", {15'd0, done1}, {15'd0, m_done[0]});
        chk("rd_valid_p1", {15'd0, rv1}, {15'd0, m_rv[0]});
        chk("rd_data_p1", rd_data1, int2bcd(m_rd[0]));
        chk("snap_miss_p1", {15'd0, miss1}, {15'd0, m_miss[0]});
        chk("count_p3", count3, int2bcd(m_cnt[1]));
        chk("busy_p3", {15'd0, busy3}, {15'd0, m_busy[1]});
        chk("done_p3", {15'd0, done3}, {15'd0, m_done[1]});
        chk("rd_valid_p3", {15'd0, rv3}, {15'd0, m_rv[1]});
        chk("rd_data_p3", rd_data3, int2bcd(m_rd[1]));
        chk("snap_miss_p3", {15'd0, miss3}, {15'd0, m_miss[1]});
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            model_step();
            check_all();
        end
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cycle(1);
        stop = 1'b0;
    endtask

    initial begin
        #1 clear_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 clear_n = 1'b1;

        // count up to 0012 and stop there
        limit = 16'h0012;
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        ndone = 0;
        repeat (40) begin
            cycle(1);
            if (done1) ndone++;
        end
        chk("done_pulses_p1", 16'(ndone), 16'd1);
        chk("hold_limit_p1", count1, 16'h0012);
        chk("hold_limit_p3", count3, 16'h0012);

        // carry across digits and all-9s wrap
        pulse_stop();
        load_value = 16'h0099;
        load = 1'b1;
        cycle(1);
        load = 1'b0;
        limit = 16'hFFFF;
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        cycle(1);
        chk("first_tick_p1", count1, 16'h0100);
        cycle(5);
        pulse_stop();
        load_value = 16'h9998;
        load = 1'b1;
        cycle(1);
        load = 1'b0;
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        cycle(2);
        chk("wrap_p1", count1, 16'h0000);
        chk("wrap_nodone_p1", {15'd0, done1}, 16'd0);
        cycle(1);

        // pause keeps the prescaler phase
        pulse_stop();
        pulse_stop();
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        cycle(6);
        pulse_stop();
        cycle(10);
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        cycle(10);

        // snapshot hold, miss and handshake
        pulse_stop();
        pulse_stop();
        load_value = 16'h0042;
        load = 1'b1;
        cycle(1);
        load = 1'b0;
        rd_ready = 1'b0;
        snap = 1'b1;
        cycle(1);
        snap = 1'b0;
        chk("snap_data_p1", rd_data1, 16'h0042);
        cycle(5);
        snap = 1'b1;
        cycle(1);
        snap = 1'b0;
        chk("snap_miss_set_p1", {15'd0, miss1}, 16'd1);
        chk("snap_data_held_p1", rd_data1, 16'h0042);
        rd_ready = 1'b1;
        cycle(1);
        rd_ready = 1'b0;
        chk("snap_cleared_p1", {15'd0, rv1}, 16'd0);

        // asynchronous reset in the middle of a run
        load_value = 16'h0530;
        load = 1'b1;
        cycle(1);
        load = 1'b0;
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        cycle(7);
        chk("pre_reset_p1", count1, 16'h0537);
        #2 clear_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 clear_n = 1'b1;
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        cycle(1);
        chk("resume_p1", count1, 16'h0001);

`ifdef BCD_DOWN_EN
        // down count through the all-0s wrap
        pulse_stop();
        pulse_stop();
        dir = 1'b1;
        load_value = 16'h0001;
        load = 1'b1;
        cycle(1);
        load = 1'b0;
        limit = 16'h9998;
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        cycle(1);
        chk("down_zero_p1", count1, 16'h0000);
        cycle(1);
        chk("down_wrap_p1", count1, 16'h9999);
        cycle(1);
        chk("down_limit_p1", count1, 16'h9998);
        chk("down_done_p1", {15'd0, done1}, 16'd1);
        dir = 1'b0;
`endif

        // randomized commands against the model
        limit = int2bcd(20);
        repeat (400) begin
            start = ($urandom_range(0, 9) < 2);
            stop = ($urandom_range(0, 9) == 0);
            load = ($urandom_range(0, 9) < 2);
            load_value = 16'($urandom);
            snap = ($urandom_range(0, 9) < 3);
            rd_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0) limit = 16'hFFFF;
                else limit = int2bcd(int'($urandom_range(0, 40)));
            end
`ifdef BCD_DOWN_EN
            dir = 1'($urandom_range(0, 1));
`endif
            cycle(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
